// File: rtl/jt51_acc_unit.sv
// -----------------------------------------------------------------------------
// jt51_acc_unit
// Per-sample output accumulator for a 32-slot FM operator pipeline.
// Each cen=1 clock processes one operator slot. Carrier outputs for the
// current channel algorithm are summed into 19-bit left/right accumulators.
// At every sample boundary (cen=1 with m1_enters=1) the sums are saturated to
// 16 bits and published. A low-resolution copy with a 10-bit mantissa is
// published at the same time.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cen                 clock enable, one slot per enabled edge
//   m1/m2/c1/c2_enters  first-slot pulses of the four 8-slot groups
//   op31_acc            marks slot 31 (channel 7, C2)
//   rl_I[1:0]           channel output enables: bit0 left, bit1 right
//   con_I[2:0]          channel connection algorithm
//   op_out[13:0]        signed operator output of the current slot
//   ne, noise_mix[11:0] noise enable and signed noise sample (slot 31 only)
//   xleft, xright       saturated full-resolution sample
//   left, right         saturated sample with a 10-bit mantissa
// -----------------------------------------------------------------------------
module jt51_acc_unit (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               m1_enters,
    input  logic               m2_enters,
    input  logic               c1_enters,
    input  logic               c2_enters,
    input  logic               op31_acc,
    input  logic [1:0]         rl_I,
    input  logic [2:0]         con_I,
    input  logic signed [13:0] op_out,
    input  logic               ne,
    input  logic signed [11:0] noise_mix,
    output logic signed [15:0] xleft,
    output logic signed [15:0] xright,
    output logic signed [15:0] left,
    output logic signed [15:0] right
);

    typedef enum logic [1:0] {
        GRP_M1 = 2'd0,
        GRP_M2 = 2'd1,
        GRP_C1 = 2'd2,
        GRP_C2 = 2'd3
    } grp_t;

    grp_t               grp_r;
    grp_t               grp_s;
    logic               sum_en_s;
    logic signed [13:0] slot_val_s;
    logic signed [18:0] slot_ext_s;
    logic signed [18:0] contrib_l_s;
    logic signed [18:0] contrib_r_s;
    logic signed [18:0] acc_l_r;
    logic signed [18:0] acc_r_r;
    logic signed [15:0] sat_l_s;
    logic signed [15:0] sat_r_s;

    // Clamp a 19-bit sum into the signed 16-bit output range.
    function automatic logic signed [15:0] sat16(input logic signed [18:0] x);
        if (x > 19'sd32767) begin
            sat16 = 16'sd32767;
        end else if (x < -19'sd32768) begin
            sat16 = -16'sd32768;
        end else begin
            sat16 = x[15:0];
        end
    endfunction

    // Keep a 10-bit mantissa: pick the smallest exponent that brings the
    // value into [-512, 511], then clear the bits shifted out.
    function automatic logic signed [15:0] lowres(input logic signed [15:0] x);
        logic signed [15:0] sh;
        logic               done;
        lowres = x;
        done   = 1'b0;
        for (int e = 0; e < 7; e++) begin
            sh = x >>> e;
            if (!done && (sh >= -16'sd512) && (sh <= 16'sd511)) begin
                lowres = sh <<< e;
                done   = 1'b1;
            end else begin
                done   = done;
            end
        end
    endfunction

    // Group of the current slot: an enters pulse takes effect in its own slot.
    always_comb begin
        grp_s = grp_r;
        if (m1_enters) begin
            grp_s = GRP_M1;
        end else if (m2_enters) begin
            grp_s = GRP_M2;
        end else if (c1_enters) begin
            grp_s = GRP_C1;
        end else if (c2_enters) begin
            grp_s = GRP_C2;
        end else begin
            grp_s = grp_r;
        end
    end

    // Decide whether this slot is a carrier for the channel's algorithm.
    always_comb begin
        sum_en_s = 1'b0;
        case (grp_s)
            GRP_M1:  sum_en_s = (con_I == 3'd7);
            GRP_M2:  sum_en_s = (con_I >= 3'd5);
            GRP_C1:  sum_en_s = (con_I >= 3'd4);
            GRP_C2:  sum_en_s = 1'b1;
            default: sum_en_s = 1'b0;
        endcase
    end

    // Select the slot value (noise replaces slot 31) and gate it per side.
    always_comb begin
        slot_val_s = op_out;
        if (ne && op31_acc) begin
            slot_val_s = {noise_mix, 2'b00};
        end else begin
            slot_val_s = op_out;
        end
        slot_ext_s  = {{5{slot_val_s[13]}}, slot_val_s};
        contrib_l_s = (sum_en_s && rl_I[0]) ? slot_ext_s : 19'sd0;
        contrib_r_s = (sum_en_s && rl_I[1]) ? slot_ext_s : 19'sd0;
    end

    assign sat_l_s = sat16(acc_l_r);
    assign sat_r_s = sat16(acc_r_r);

    // Slot accumulation, group tracking and sample-boundary output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_r   <= GRP_M1;
            acc_l_r <= 19'sd0;
            acc_r_r <= 19'sd0;
            xleft   <= 16'sd0;
            xright  <= 16'sd0;
            left    <= 16'sd0;
            right   <= 16'sd0;
        end else if (cen) begin
            grp_r <= grp_s;
            if (m1_enters) begin
                xleft   <= sat_l_s;
                xright  <= sat_r_s;
                left    <= lowres(sat_l_s);
                right   <= lowres(sat_r_s);
                acc_l_r <= contrib_l_s;
                acc_r_r <= contrib_r_s;
            end else begin
                acc_l_r <= acc_l_r + contrib_l_s;
                acc_r_r <= acc_r_r + contrib_r_s;
            end
        end else begin
            grp_r <= grp_r;
        end
    end

endmodule

// File: tb/tb_jt51_acc_unit.sv
// -----------------------------------------------------------------------------
// tb_jt51_acc_unit
// Directed-vector bench for jt51_acc_unit. Each sample is 32 slots with the
// group pulses at slots 0/8/16/24. A following boundary slot (contributing 0)
// publishes the accumulated sample, which is then compared to hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_jt51_acc_unit;

    logic               clk;
    logic               rst_n;
    logic               cen;
    logic               m1_enters;
    logic               m2_enters;
    logic               c1_enters;
    logic               c2_enters;
    logic               op31_acc;
    logic [1:0]         rl_I;
    logic [2:0]         con_I;
    logic signed [13:0] op_out;
    logic               ne;
    logic signed [11:0] noise_mix;
    logic signed [15:0] xleft;
    logic signed [15:0] xright;
    logic signed [15:0] left;
    logic signed [15:0] right;

    int checks_r   = 0;
    int failures_r = 0;
    int prio_mode  = 0;
    int resel_slot = -1;
    int stall_mode = 0;

    jt51_acc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .m1_enters (m1_enters),
        .m2_enters (m2_enters),
        .c1_enters (c1_enters),
        .c2_enters (c2_enters),
        .op31_acc  (op31_acc),
        .rl_I      (rl_I),
        .con_I     (con_I),
        .op_out    (op_out),
        .ne        (ne),
        .noise_mix (noise_mix),
        .xleft     (xleft),
        .xright    (xright),
        .left      (left),
        .right     (right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int xl, input int xr,
                             input int l, input int r);
        check_val({tag, ".xleft"},  int'(xleft),  xl);
        check_val({tag, ".xright"}, int'(xright), xr);
        check_val({tag, ".left"},   int'(left),   l);
        check_val({tag, ".right"},  int'(right),  r);
    endtask

    // One enabled slot; inputs change 1 time unit after the active edge.
    task automatic drive_slot(input int i, input int con, input int rl,
                              input int op, input int nen, input int nz);
        cen       = 1'b1;
        m1_enters = (i == 0);
        m2_enters = (i == 8);
        c1_enters = (i == 16) || (prio_mode != 0 && i == 8);
        c2_enters = (i == 24) || (i == resel_slot);
        op31_acc  = (i == 31);
        con_I     = 3'(con);
        rl_I      = 2'(rl);
        op_out    = 14'(op);
        ne        = nen[0];
        noise_mix = 12'(nz);
        @(posedge clk);
        #1;
        if (stall_mode != 0 && i == 12) begin
            for (int k = 0; k < 10; k++) begin
                cen       = 1'b0;
                m1_enters = 1'($urandom_range(0, 1));
                m2_enters = 1'($urandom_range(0, 1));
                c1_enters = 1'($urandom_range(0, 1));
                c2_enters = 1'($urandom_range(0, 1));
                op31_acc  = 1'($urandom_range(0, 1));
                con_I     = 3'($urandom_range(0, 7));
                rl_I      = 2'($urandom_range(0, 3));
                op_out    = 14'($urandom);
                ne        = 1'b1;
                noise_mix = 12'($urandom);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_slots(input int first, input int last, input int con,
                             input int rl, input int op, input int nen, input int nz);
        for (int i = first; i <= last; i++) begin
            drive_slot(i, con, rl, op, nen, nz);
        end
    endtask

    // Boundary slot with no contribution, then compare published sample.
    task automatic boundary_check(input string tag, input int xl, input int xr,
                                  input int l, input int r);
        drive_slot(0, 0, 0, 0, 0, 0);
        check_out(tag, xl, xr, l, r);
    endtask

    initial begin
        rst_n = 1'b0;
        cen = 1'b1; m1_enters = 1'b1; m2_enters = 1'b0; c1_enters = 1'b0;
        c2_enters = 1'b0; op31_acc = 1'b0; rl_I = 2'd3; con_I = 3'd7;
        op_out = 14'sd100; ne = 1'b0; noise_mix = 12'sd0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        run_slots(0, 5, 7, 3, 100, 0, 0);
        check_out("pre_boundary", 0, 0, 0, 0);
        run_slots(6, 31, 7, 3, 100, 0, 0);
        boundary_check("first_partial", 3200, 3200, 3200, 3200);

        run_slots(0, 31, 7, 3, 100, 0, 0);
        boundary_check("con7_100", 3200, 3200, 3200, 3200);

        run_slots(0, 31, 0, 1, 100, 0, 0);
        boundary_check("con0_left", 800, 0, 800, 0);

        run_slots(0, 31, 7, 3, 8191, 0, 0);
        boundary_check("sat_pos", 32767, 32767, 32704, 32704);

        run_slots(0, 31, 7, 3, -8192, 0, 0);
        boundary_check("sat_neg", -32768, -32768, -32768, -32768);

        run_slots(0, 31, 0, 2, 0, 1, 256);
        boundary_check("noise_on", 0, 1024, 0, 1024);

        run_slots(0, 31, 0, 2, 0, 0, 256);
        boundary_check("noise_off", 0, 0, 0, 0);

        run_slots(0, 31, 1, 1, 300, 0, 0);
        boundary_check("lowres_e3", 2400, 0, 2400, 0);

        stall_mode = 1;
        run_slots(0, 31, 7, 3, 100, 0, 0);
        stall_mode = 0;
        boundary_check("stall", 3200, 3200, 3200, 3200);

        prio_mode = 1;
        run_slots(0, 31, 4, 1, 1, 0, 0);
        prio_mode = 0;
        boundary_check("priority", 16, 0, 16, 0);

        resel_slot = 4;
        run_slots(0, 31, 0, 1, 1, 0, 0);
        resel_slot = -1;
        boundary_check("reselect", 12, 0, 12, 0);

        // Mid-sample reset with live inputs after a nonzero sample.
        run_slots(0, 31, 7, 3, 100, 0, 0);
        run_slots(0, 20, 7, 3, 100, 0, 0);
        check_out("pre_reset", 3200, 3200, 3200, 3200);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_out("after_release", 0, 0, 0, 0);
        run_slots(16, 31, 4, 1, 10, 0, 0);
        check_out("post_reset_hold", 0, 0, 0, 0);
        boundary_check("post_reset", 160, 0, 160, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/jt51_acc_unit.md
JT51_ACC_UNIT -- requirements
Module: jt51_acc

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 cen  input  1  clock enable; one operator slot is processed per clk edge with cen=1.
REQ-004 m1_enters, m2_enters, c1_enters, c2_enters  input  1 each  one-slot pulses marking the first slot of the M1, M2, C1 and C2 groups (8 slots each, 32 slots per sample).
REQ-005 op31_acc  input  1  marks slot 31 (channel 7, C2).
REQ-006 rl_I  input  2  output enable of the current slot's channel: bit0 = left, bit1 = right.
REQ-007 con_I  input  3  connection algorithm of the current slot's channel.
REQ-008 op_out  input  14 signed  operator output of the current slot, time-aligned with rl_I and con_I.
REQ-009 ne  input  1  noise enable.
REQ-010 noise_mix  input  12 signed  noise sample, used in slot 31 when ne=1.
REQ-011 xleft, xright  output  16 signed  full-resolution sample.
REQ-012 left, right  output  16 signed  low-resolution sample with a 10-bit mantissa.

Function
REQ-013 Group tracking: each *_enters pulse with cen=1 selects the group for that slot and the following 7 slots.
REQ-014 Slot enable by group: C2 is always summed; C1 when con_I>=4; M2 when con_I>=5; M1 only when con_I=7.
REQ-015 Slot value: when ne=1 and op31_acc=1, the value is noise_mix sign-extended and shifted left 2 (14 bits); otherwise it is op_out. ne is ignored in all other slots.
REQ-016 The enabled slot value, sign-extended, is added to a 19-bit left accumulator if rl_I[0]=1 and to a 19-bit right accumulator if rl_I[1]=1. The 19-bit width cannot overflow over 32 slots.
REQ-017 Sample boundary is a cen=1 cycle with m1_enters=1. On that cycle:
- xleft/xright are loaded with the saturated accumulator values.
- Each accumulator restarts with that cycle's slot contribution only.
REQ-018 Saturation: values above 32767 clamp to 32767; values below -32768 clamp to -32768.
REQ-019 Low-resolution conversion, per channel from the saturated value x:
- e is the smallest value in 0..6 such that x>>>e lies in [-512, 511].
- The output is (x>>>e)<<e, i.e. the low e bits are cleared with an arithmetic shift.
REQ-020 left, right, xleft and xright all update on the same clk edge, one clk after the boundary cycle is sampled, and hold until the next boundary.
REQ-021 With cen=0, no state changes and all inputs are ignored.
REQ-022 Simultaneous *_enters pulses: priority is m1 > m2 > c1 > c2.
REQ-023 An enters pulse arriving mid-group re-selects the group immediately. There is no slot counter and no error flag.
REQ-024 Samples before the first m1_enters are undefined only in content. The outputs stay at 0 until the first boundary.

Reset
REQ-025 While rst_n=0, the following are forced to 0 asynchronously: xleft, xright, left, right, both accumulators.
REQ-026 While rst_n=0, the group register is forced to M1.
REQ-027 Reset asserted mid-sample discards the partial sums. The first boundary after release outputs only slots accumulated since release.

Verification
REQ-028 Assert rst_n=0 with inputs active -> all four outputs read 0 immediately and remain 0 through release until the first boundary.
REQ-029 con=7, rl=3, op_out=100 for all 32 slots, then the next m1_enters -> xleft=xright=3200, left=right=3200.
REQ-030 con=0, rl=1, op_out=100 for all slots -> xleft=800, xright=0, left=800, right=0.
REQ-031 con=7, rl=3, op_out=8191 for all slots -> xleft=xright=32767, left=right=32704.
REQ-032 con=0, rl=2, ne=1, op_out=0, noise_mix=256 -> xright=1024, right=1024, xleft=0. Repeating with ne=0 gives 0 on all outputs.
REQ-033 Hold cen=0 for 10 clks mid-sample while toggling inputs -> results identical to a run without the stall.
